// File: rtl/act_mem_burst_reader.sv
// Activation row memory with a precision-aware burst read engine and a 2-entry output FIFO.
// Optional performance counters are enabled by defining ACT_MEM_PERF_CNT_EN.
module act_mem_burst_reader #(
   parameter int PMAX        = 8,
   parameter int PMIN        = 2,
   parameter int NUM_BANKS   = PMAX / PMIN,
   parameter int DATA_WIDTH  = PMAX * NUM_BANKS,
   parameter int MEM_DEPTH   = 256,
   parameter int ROW_AW      = $clog2(MEM_DEPTH),
   parameter int PMODE_WIDTH = $clog2(NUM_BANKS) + 1,
   parameter int LADDR_W     = ROW_AW + $clog2(NUM_BANKS),
   parameter int LEN_W       = LADDR_W + 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [PMODE_WIDTH-1:0] precision_mode,
   input  logic                   wr_en,
   input  logic [ROW_AW-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_start,
   input  logic [LADDR_W-1:0]     rd_base,
   input  logic [LEN_W-1:0]       rd_len,
   output logic                   rd_busy,
   output logic                   rd_done,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_WIDTH-1:0]  out_data
`ifdef ACT_MEM_PERF_CNT_EN
   ,
   output logic [31:0]            stall_cycles,
   output logic [31:0]            wr_conflicts
`endif
);

   localparam int MAX_MODE = $clog2(NUM_BANKS);
   localparam int NUM_CAND = 2 * NUM_BANKS;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];
   logic [LADDR_W-1:0]     r_addr;
   logic [LEN_W-1:0]       r_remain;
   logic [PMODE_WIDTH-1:0] r_mode;
   logic                   r_zero_done;
   logic [DATA_WIDTH-1:0]  r_fifo [2];
   logic                   r_wptr;
   logic                   r_rptr;
   logic [1:0]             r_count;

   logic                   w_accept;
   logic                   w_issue;
   logic                   w_pop;
   logic                   w_last_pop;
   logic [PMODE_WIDTH-1:0] w_mode_clamped;
   logic [ROW_AW-1:0]      w_row_idx;
   logic [PMODE_WIDTH-1:0] w_one;
   logic [PMODE_WIDTH-1:0] w_hidx;
   logic [DATA_WIDTH-1:0]  w_rd_row;
   logic [DATA_WIDTH-1:0]  w_cand [NUM_CAND];

   assign w_mode_clamped = (precision_mode > PMODE_WIDTH'(MAX_MODE)) ? PMODE_WIDTH'(MAX_MODE)
                                                                      : precision_mode;

   // Row is the logical address shifted by the mode; truncation wraps at the top of memory.
   assign w_row_idx = ROW_AW'(r_addr >> r_mode);
   assign w_rd_row  = r_mem[w_row_idx];

   // Candidates are laid out heap-style: mode m, sub-index s lives at (2^m - 1) + s.
   assign w_one  = PMODE_WIDTH'(1) << r_mode;
   assign w_hidx = (w_one | (PMODE_WIDTH'(r_addr) & (w_one - PMODE_WIDTH'(1)))) - PMODE_WIDTH'(1);

   for (genvar m = 0; m <= MAX_MODE; m++) begin : g_mode
      localparam int SW = DATA_WIDTH >> m;
      for (genvar s = 0; s < (1 << m); s++) begin : g_sub
         assign w_cand[(1 << m) - 1 + s] = {(1 << m){w_rd_row[s*SW +: SW]}};
      end
   end
   assign w_cand[NUM_CAND-1] = '0;

   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_fifo[r_rptr];
   assign w_pop     = out_valid & out_ready;
   assign rd_busy   = (r_state != S_IDLE);
   assign rd_done   = r_zero_done | w_last_pop;

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_issue     = 1'b0;
      w_last_pop  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rd_start) begin
               w_accept = 1'b1;
               if (rd_len != '0) w_state_nxt = S_BURST;
            end
         end
         S_BURST: begin
            if (!wr_en && (r_count < 2'd2)) begin
               w_issue = 1'b1;
               if (r_remain == LEN_W'(1)) w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_count == 2'd0) begin
               w_state_nxt = S_IDLE;
            end else if ((r_count == 2'd1) && w_pop) begin
               w_last_pop  = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: the row array has no reset; contents survive reset and the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) r_mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr      <= '0;
         r_remain    <= '0;
         r_mode      <= '0;
         r_zero_done <= 1'b0;
         r_fifo[0]   <= '0;
         r_fifo[1]   <= '0;
         r_wptr      <= 1'b0;
         r_rptr      <= 1'b0;
         r_count     <= 2'd0;
      end else begin
         r_zero_done <= w_accept && (rd_len == '0);
         if (w_accept) begin
            r_addr   <= rd_base;
            r_remain <= rd_len;
            r_mode   <= w_mode_clamped;
         end else if (w_issue) begin
            r_addr   <= r_addr + LADDR_W'(1);
            r_remain <= r_remain - LEN_W'(1);
         end
         // The registered memory read lands directly in the FIFO slot.
         if (w_issue) begin
            r_fifo[r_wptr] <= w_cand[w_hidx];
            r_wptr         <= ~r_wptr;
         end
         if (w_pop) r_rptr <= ~r_rptr;
         case ({w_issue, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef ACT_MEM_PERF_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_wr_conflicts;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_wr_conflicts <= '0;
      end else if (w_accept) begin
         r_stall_cycles <= '0;
         r_wr_conflicts <= '0;
      end else begin
         if ((r_state != S_IDLE) && out_valid && !out_ready && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if ((r_state == S_BURST) && wr_en && (r_count < 2'd2) && (r_wr_conflicts != '1))
            r_wr_conflicts <= r_wr_conflicts + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign wr_conflicts = r_wr_conflicts;
`endif

endmodule

// File: tb/tb_act_mem_burst_reader.sv
// Directed self-checking bench for act_mem_burst_reader (counters checked when ACT_MEM_PERF_CNT_EN is set).
module tb_act_mem_burst_reader;

   logic        clk;
   logic        reset;
   logic [2:0]  precision_mode;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_start;
   logic [9:0]  rd_base;
   logic [10:0] rd_len;
   logic        rd_busy;
   logic        rd_done;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef ACT_MEM_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] wr_conflicts;
`endif

   act_mem_burst_reader dut (
      .clk            (clk),
      .reset          (reset),
      .precision_mode (precision_mode),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .rd_start       (rd_start),
      .rd_base        (rd_base),
      .rd_len         (rd_len),
      .rd_busy        (rd_busy),
      .rd_done        (rd_done),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data)
`ifdef ACT_MEM_PERF_CNT_EN
      ,
      .stall_cycles   (stall_cycles),
      .wr_conflicts   (wr_conflicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          start_cyc;
   int          first_valid_cyc = -1;
   int          done_cyc = -1;
   int          done_cnt = 0;
   logic        stall_prev = 1'b0;
   logic [31:0] stall_data;
   logic [31:0] rx_q  [$];
   logic [31:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Beat collector and hold-while-stalled checker.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid_held", 32'(out_valid), 32'd1);
            check("stall_data_held", out_data, stall_data);
         end
         if (out_valid && out_ready) rx_q.push_back(out_data);
         if (out_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
         if (rd_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   task automatic write_row(input logic [7:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   // Pulses rd_start in cycle 0 and returns early in cycle 1.
   task automatic start_burst(input logic [9:0] b, input logic [10:0] l, input logic [2:0] m);
      @(posedge clk); #1;
      rx_q.delete();
      done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
      rd_start = 1'b1; rd_base = b; rd_len = l; precision_mode = m;
      start_cyc = cyc;
      @(posedge clk); #1;
      rd_start = 1'b0;
   endtask

   task automatic run_burst(input logic [3:0] pat, input int budget);
      int i;
      i = 0;
      while ((done_cnt == 0) && (i < budget)) begin
         out_ready = pat[2'(i % 4)];
         @(negedge clk);
         i++;
         if (done_cnt == 0) begin
            @(posedge clk); #1;
         end
      end
      check("burst_done_in_budget", 32'(done_cnt != 0), 32'd1);
      out_ready = 1'b1;
   endtask

   task automatic check_beats(input string tag);
      check($sformatf("%s_count", tag), 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; (i < rx_q.size()) && (i < exp_q.size()); i++)
         check($sformatf("%s_beat%0d", tag, i), rx_q[i], exp_q[i]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; precision_mode = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_start = 1'b0; rd_base = '0; rd_len = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_rd_busy",   32'(rd_busy),   32'd0);
      check("reset_rd_done",   32'(rd_done),   32'd0);
      check("reset_out_data",  out_data,       32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Mode 0 burst with latency and completion timing.
      write_row(8'd0, 32'h03020100);
      write_row(8'd1, 32'h07060504);
      write_row(8'd2, 32'h0B0A0908);
      write_row(8'd3, 32'h0F0E0D0C);
      start_burst(10'd0, 11'd4, 3'd0);
      run_burst(4'b1111, 40);
      exp_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      check_beats("mode0");
      check("mode0_first_valid_cycle", 32'(first_valid_cyc - start_cyc), 32'd2);
      check("mode0_done_cycle",        32'(done_cyc - start_cyc),        32'd5);

      // Mode 2 replicate, then mode 3 which clamps to mode 2.
      write_row(8'd5, 32'hDDCCBBAA);
      exp_q = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
      start_burst(10'd20, 11'd4, 3'd2);
      run_burst(4'b1111, 40);
      check_beats("mode2");
      start_burst(10'd20, 11'd4, 3'd3);
      run_burst(4'b1111, 40);
      check_beats("mode3_clamp");

      // Mode 1 with out_ready pattern 1,0,0,1.
      exp_q = '{32'h01000100, 32'h03020302, 32'h05040504, 32'h07060706, 32'h09080908, 32'h0B0A0B0A};
      start_burst(10'd0, 11'd6, 3'd1);
      run_burst(4'b1001, 80);
      check_beats("backpressure");

      // Writes block issues in cycles 1..3: completion moves from cycle 5 to 8.
      start_burst(10'd0, 11'd4, 3'd0);
      wr_en = 1'b1; wr_addr = 8'd200; wr_data = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1 wr_en = 1'b0;
      run_burst(4'b1111, 40);
      exp_q = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
      check_beats("wr_conflict");
      check("wr_conflict_done_cycle", 32'(done_cyc - start_cyc), 32'd8);
      start_burst(10'd200, 11'd1, 3'd0);
      run_burst(4'b1111, 20);
      exp_q = '{32'hCAFEF00D};
      check_beats("row200_readback");

      // Row 1 written in cycle 2, read issued in cycle 3.
      start_burst(10'd0, 11'd4, 3'd0);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 8'd1; wr_data = 32'h11223344;
      @(posedge clk); #1;
      wr_en = 1'b0;
      run_burst(4'b1111, 40);
      exp_q = '{32'h03020100, 32'h11223344, 32'h0B0A0908, 32'h0F0E0D0C};
      check_beats("wr_then_rd");
      check("wr_then_rd_done_cycle", 32'(done_cyc - start_cyc), 32'd6);

      // Zero-length burst.
      start_burst(10'd0, 11'd0, 3'd0);
      repeat (4) @(negedge clk);
      check("len0_done_count",  32'(done_cnt), 32'd1);
      check("len0_done_cycle",  32'(done_cyc - start_cyc), 32'd1);
      check("len0_no_valid",    32'(first_valid_cyc), 32'hFFFFFFFF);
      check("len0_not_busy",    32'(rd_busy), 32'd0);

      // Logical address wraps from row 255 sub 3 to row 0 sub 0.
      write_row(8'd255, 32'h44332211);
      write_row(8'd0,   32'h000000E7);
      start_burst(10'd1023, 11'd2, 3'd2);
      run_burst(4'b1111, 20);
      exp_q = '{32'h44444444, 32'hE7E7E7E7};
      check_beats("wrap");

      // rd_start while busy is ignored.
      start_burst(10'd8, 11'd4, 3'd2);
      rd_start = 1'b1; rd_base = 10'd20; rd_len = 11'd1; precision_mode = 3'd0;
      @(posedge clk); #1;
      rd_start = 1'b0;
      run_burst(4'b1111, 40);
      repeat (4) @(negedge clk);
      exp_q = '{32'h08080808, 32'h09090909, 32'h0A0A0A0A, 32'h0B0B0B0B};
      check_beats("busy_ignore");
      check("busy_ignore_done_count", 32'(done_cnt), 32'd1);
      check("busy_ignore_idle",       32'(rd_busy),  32'd0);
      check("busy_ignore_no_valid",   32'(out_valid), 32'd0);

      // Reset while draining.
      out_ready = 1'b0;
      start_burst(10'd0, 11'd2, 3'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("drain_busy_before_reset",  32'(rd_busy),   32'd1);
      check("drain_valid_before_reset", 32'(out_valid), 32'd1);
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("reset_drain_out_valid", 32'(out_valid), 32'd0);
      check("reset_drain_rd_busy",   32'(rd_busy),   32'd0);
      check("reset_drain_rd_done",   32'(rd_done),   32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      check("reset_drain_no_done",  32'(done_cnt),  32'd0);
      check("reset_drain_no_valid", 32'(out_valid), 32'd0);

`ifdef ACT_MEM_PERF_CNT_EN
      // Five stalled DRAIN cycles (2..6), released in cycle 7.
      out_ready = 1'b0;
      start_burst(10'd0, 11'd1, 3'd0);
      repeat (6) @(posedge clk);
      #1;
      run_burst(4'b1111, 20);
      check("perf_stall_cycles", stall_cycles, 32'd5);
      start_burst(10'd0, 11'd4, 3'd0);
      wr_en = 1'b1; wr_addr = 8'd200; wr_data = 32'hCAFEF00D;
      repeat (3) @(posedge clk);
      #1 wr_en = 1'b0;
      run_burst(4'b1111, 40);
      check("perf_wr_conflicts",      wr_conflicts, 32'd3);
      check("perf_stall_cleared",     stall_cycles, 32'd0);
      start_burst(10'd0, 11'd0, 3'd0);
      @(negedge clk);
      check("perf_conflicts_cleared", wr_conflicts, 32'd0);
      check("perf_stall_still_zero",  stall_cycles, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
